alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

ID/EX issue register feeding the ALU. Decodes an RV32I instruction into the 5-bit ALU control code and the ALU operand pair, computes the branch/jump target, and holds everything in a single-entry pipeline register with valid/ready handshakes on both sides. Decode sits upstream and the execute stage (ALU + branch resolution) sits downstream; the stage supports back-pressure and flush.

## Interface
- XLEN, 32, datapath width; 32 is the only legal value.
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- in_valid_i  in  1  decode presents an instruction.
- in_ready_o  out  1  stage accepts this cycle.
- Instr_i  in  32  instruction word.
- PC_i  in  32  instruction address.
- RD1_i  in  32  rs1 read data.
- RD2_i  in  32  rs2 read data.
- flush_i  in  1  discard held and incoming entry.
- out_valid_o  out  1  registered entry valid.
- out_ready_i  in  1  execute consumes entry.
- ALUCtrl_o  out  5  ALU op code: 0 add, 1 sub, 2 sll-reg, 3 sll-imm, 4 slt, 5 sltu, 6 xor, 7 srl-reg, 8 sra-reg, 9 srl-imm, 10 sra-imm, 11 or, 12 and.
- SrcA_o  out  32  ALU operand A.
- SrcB_o  out  32  ALU operand B.
- StoreData_o  out  32  rs2 data for stores, 0 otherwise.
- JmpTgt_o  out  32  branch/jump target.
- Rd_o  out  5  destination register.
- RegWrite_o, MemRead_o, MemWrite_o, Branch_o, Jump_o, Illegal_o  out  1 each  control flags.
- BrCond_o  out  3  branch funct3, resolved downstream against ALU flags {zero, gt(signed >=), gtu(unsigned >=)}.

## Operation
- Decode is combinational on Instr_i/PC_i/RD1_i/RD2_i; the result is captured in the output register on accept.
- OP (0110011): SrcA=RD1, SrcB=RD2; funct3/funct7: 000/00→0, 000/20→1, 001/00→2, 010/00→4, 011/00→5, 100/00→6, 101/00→7, 101/20→8, 110/00→11, 111/00→12; any other funct7 is illegal.
- OP-IMM (0010011): SrcA=RD1; ADDI 0, SLTI 4, SLTIU 5, XORI 6, ORI 11, ANDI 12 with SrcB=sign-extended I-imm. SLLI (funct7 00)→3, SRLI (00)→9, SRAI (20)→10 with SrcB={27'b0, shamt}; any other funct7 is illegal.
- LOAD: code 0, SrcA=RD1, SrcB=I-imm, MemRead, RegWrite. STORE: code 0, SrcB=S-imm, MemWrite, StoreData=RD2.
- BRANCH: code 1, SrcA=RD1, SrcB=RD2, Branch, BrCond=funct3, JmpTgt=PC+B-imm; funct3 010/011 is illegal.
- LUI: code 0, SrcA=0, SrcB=U-imm. AUIPC: code 0, SrcA=PC, SrcB=U-imm.
- JAL: code 0, SrcA=PC, SrcB=4, Jump, RegWrite, JmpTgt=PC+J-imm. JALR (funct3 000 only): same ALU setup, JmpTgt=(RD1+I-imm)&~1.
- Rd_o=Instr[11:7]. RegWrite_o is forced 0 when Rd=0.
- Illegal instruction or unknown opcode: Illegal_o=1, all other flags 0, ALUCtrl_o=0, operands 0, entry still passes as valid.
- All target and immediate arithmetic is modulo 2^32 with carries discarded.

## Timing
- Reset: out_valid_o=0 and every registered output is 0. in_ready_o=1 after reset.
- in_ready_o = !out_valid_o || out_ready_i (combinational, no bubble on back-to-back transfers).
- Accept when in_valid_i && in_ready_o. Registered outputs update on the next edge: latency is 1 cycle.
- While out_valid_o && !out_ready_i, all outputs hold stable.
- Entry retires on out_valid_o && out_ready_i. If there is no simultaneous accept, out_valid_o falls the next cycle.
- flush_i has priority: at the next edge out_valid_o=0, the held entry is dropped, a same-cycle accept is discarded, and the payload is zeroed.
- Asynchronous reset mid-operation drops the entry immediately.

## Test plan
- Reset: assert rst_ni=0 mid-transfer -> out_valid_o=0 and all outputs 0 without a clock edge. Release -> in_ready_o=1.
- SUB x3,x1,x2 (0x402081B3), RD1=10, RD2=3 -> next cycle ALUCtrl 1, SrcA 10, SrcB 3, Rd 3, RegWrite 1.
- SRAI x5,x6,4 (0x40435293), RD1=0x80000000 -> ALUCtrl 10, SrcA 0x80000000, SrcB 4.
- BLT x1,x2,+8 (0x0020C463), PC 0x100 -> ALUCtrl 1, Branch 1, BrCond 4, JmpTgt 0x108, RegWrite 0.
- Back-pressure: two valid instructions with out_ready_i=0 for 3 cycles -> first entry held stable, in_ready_o=0, second accepted in the cycle out_ready_i rises, no loss or duplication.
- Flush plus illegal: 0xFFFFFFFF -> Illegal_o=1 with all flags 0. Assert flush_i while it is held -> out_valid_o=0 next cycle.

Source files
------------

// File: rtl/alu_issue_if.sv
// Handshake and payload bundle between decode, the ALU issue register and execute.
// The slave modport is the issue stage; the master modport is its environment.
interface alu_issue_if #(parameter int XLEN = 32);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     Instr_i;
    logic [XLEN-1:0] PC_i;
    logic [XLEN-1:0] RD1_i;
    logic [XLEN-1:0] RD2_i;
    logic            flush_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [4:0]      ALUCtrl_o;
    logic [XLEN-1:0] SrcA_o;
    logic [XLEN-1:0] SrcB_o;
    logic [XLEN-1:0] StoreData_o;
    logic [XLEN-1:0] JmpTgt_o;
    logic [4:0]      Rd_o;
    logic            RegWrite_o;
    logic            MemRead_o;
    logic            MemWrite_o;
    logic            Branch_o;
    logic            Jump_o;
    logic            Illegal_o;
    logic [2:0]      BrCond_o;

    modport slave (
        input  in_valid_i, Instr_i, PC_i, RD1_i, RD2_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, ALUCtrl_o, SrcA_o, SrcB_o, StoreData_o,
               JmpTgt_o, Rd_o, RegWrite_o, MemRead_o, MemWrite_o, Branch_o,
               Jump_o, Illegal_o, BrCond_o
    );

    modport master (
        output in_valid_i, Instr_i, PC_i, RD1_i, RD2_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, ALUCtrl_o, SrcA_o, SrcB_o, StoreData_o,
               JmpTgt_o, Rd_o, RegWrite_o, MemRead_o, MemWrite_o, Branch_o,
               Jump_o, Illegal_o, BrCond_o
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes an RV32I word into ALU control, operands and
// branch/jump target, and holds the result in a single-entry valid/ready register.
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    alu_issue_if.slave  bus
);
    typedef struct packed {
        logic [4:0]      ctrl;
        logic [XLEN-1:0] srca;
        logic [XLEN-1:0] srcb;
        logic [XLEN-1:0] store;
        logic [XLEN-1:0] tgt;
        logic [4:0]      rd;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            branch;
        logic            jump;
        logic            illegal;
        logic [2:0]      brcond;
    } payload_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    logic [31:0]     ins_s;
    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [4:0]      rd_s;
    logic [XLEN-1:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s, shamt_s, jalr_sum_s;
    logic            illegal_s;
    payload_t        dec_s;
    payload_t        pay_q;
    logic            valid_q;
    logic            in_ready_s;
    logic            accept_s;

    assign ins_s      = bus.Instr_i;
    assign opcode_s   = ins_s[6:0];
    assign funct3_s   = ins_s[14:12];
    assign funct7_s   = ins_s[31:25];
    assign rd_s       = ins_s[11:7];
    assign imm_i_s    = {{20{ins_s[31]}}, ins_s[31:20]};
    assign imm_s_s    = {{20{ins_s[31]}}, ins_s[31:25], ins_s[11:7]};
    assign imm_b_s    = {{19{ins_s[31]}}, ins_s[31], ins_s[7], ins_s[30:25], ins_s[11:8], 1'b0};
    assign imm_u_s    = {ins_s[31:12], 12'd0};
    assign imm_j_s    = {{11{ins_s[31]}}, ins_s[31], ins_s[19:12], ins_s[20], ins_s[30:21], 1'b0};
    assign shamt_s    = {27'd0, ins_s[24:20]};
    assign jalr_sum_s = bus.RD1_i + imm_i_s;

    // Instruction decode into the next payload; illegal encodings collapse to a bare Illegal flag.
    always_comb begin
        dec_s     = '0;
        illegal_s = 1'b0;
        dec_s.rd  = rd_s;
        case (opcode_s)
            OPC_OP: begin
                dec_s.srca     = bus.RD1_i;
                dec_s.srcb     = bus.RD2_i;
                dec_s.regwrite = 1'b1;
                case ({funct7_s, funct3_s})
                    {7'h00, 3'b000}: dec_s.ctrl = 5'd0;
                    {7'h20, 3'b000}: dec_s.ctrl = 5'd1;
                    {7'h00, 3'b001}: dec_s.ctrl = 5'd2;
                    {7'h00, 3'b010}: dec_s.ctrl = 5'd4;
                    {7'h00, 3'b011}: dec_s.ctrl = 5'd5;
                    {7'h00, 3'b100}: dec_s.ctrl = 5'd6;
                    {7'h00, 3'b101}: dec_s.ctrl = 5'd7;
                    {7'h20, 3'b101}: dec_s.ctrl = 5'd8;
                    {7'h00, 3'b110}: dec_s.ctrl = 5'd11;
                    {7'h00, 3'b111}: dec_s.ctrl = 5'd12;
                    default:         illegal_s  = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                dec_s.srca     = bus.RD1_i;
                dec_s.srcb     = imm_i_s;
                dec_s.regwrite = 1'b1;
                case (funct3_s)
                    3'b000: dec_s.ctrl = 5'd0;
                    3'b010: dec_s.ctrl = 5'd4;
                    3'b011: dec_s.ctrl = 5'd5;
                    3'b100: dec_s.ctrl = 5'd6;
                    3'b110: dec_s.ctrl = 5'd11;
                    3'b111: dec_s.ctrl = 5'd12;
                    3'b001: begin
                        dec_s.srcb = shamt_s;
                        dec_s.ctrl = 5'd3;
                        illegal_s  = (funct7_s != 7'h00);
                    end
                    3'b101: begin
                        dec_s.srcb = shamt_s;
                        if (funct7_s == 7'h00) begin
                            dec_s.ctrl = 5'd9;
                        end else if (funct7_s == 7'h20) begin
                            dec_s.ctrl = 5'd10;
                        end else begin
                            illegal_s = 1'b1;
                        end
                    end
                    default: illegal_s = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec_s.srca     = bus.RD1_i;
                dec_s.srcb     = imm_i_s;
                dec_s.memread  = 1'b1;
                dec_s.regwrite = 1'b1;
            end
            OPC_STORE: begin
                dec_s.srca     = bus.RD1_i;
                dec_s.srcb     = imm_s_s;
                dec_s.store    = bus.RD2_i;
                dec_s.memwrite = 1'b1;
            end
            OPC_BRANCH: begin
                dec_s.ctrl   = 5'd1;
                dec_s.srca   = bus.RD1_i;
                dec_s.srcb   = bus.RD2_i;
                dec_s.branch = 1'b1;
                dec_s.brcond = funct3_s;
                dec_s.tgt    = bus.PC_i + imm_b_s;
                illegal_s    = (funct3_s == 3'b010) || (funct3_s == 3'b011);
            end
            OPC_LUI: begin
                dec_s.srcb     = imm_u_s;
                dec_s.regwrite = 1'b1;
            end
            OPC_AUIPC: begin
                dec_s.srca     = bus.PC_i;
                dec_s.srcb     = imm_u_s;
                dec_s.regwrite = 1'b1;
            end
            OPC_JAL: begin
                dec_s.srca     = bus.PC_i;
                dec_s.srcb     = 32'd4;
                dec_s.jump     = 1'b1;
                dec_s.regwrite = 1'b1;
                dec_s.tgt      = bus.PC_i + imm_j_s;
            end
            OPC_JALR: begin
                dec_s.srca     = bus.PC_i;
                dec_s.srcb     = 32'd4;
                dec_s.jump     = 1'b1;
                dec_s.regwrite = 1'b1;
                dec_s.tgt      = jalr_sum_s & ~32'd1;
                illegal_s      = (funct3_s != 3'b000);
            end
            default: illegal_s = 1'b1;
        endcase
        if (illegal_s) begin
            dec_s         = '0;
            dec_s.illegal = 1'b1;
            dec_s.rd      = rd_s;
        end else begin
            dec_s.regwrite = dec_s.regwrite && (rd_s != 5'd0);
        end
    end

    assign in_ready_s = !valid_q || bus.out_ready_i;
    assign accept_s   = bus.in_valid_i && in_ready_s;

    // Pipeline register: flush wins over accept, retire clears valid when nothing new arrives.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            pay_q   <= '0;
        end else if (bus.flush_i) begin
            valid_q <= 1'b0;
            pay_q   <= '0;
        end else if (accept_s) begin
            valid_q <= 1'b1;
            pay_q   <= dec_s;
        end else if (bus.out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready_o  = in_ready_s;
    assign bus.out_valid_o = valid_q;
    assign bus.ALUCtrl_o   = pay_q.ctrl;
    assign bus.SrcA_o      = pay_q.srca;
    assign bus.SrcB_o      = pay_q.srcb;
    assign bus.StoreData_o = pay_q.store;
    assign bus.JmpTgt_o    = pay_q.tgt;
    assign bus.Rd_o        = pay_q.rd;
    assign bus.RegWrite_o  = pay_q.regwrite;
    assign bus.MemRead_o   = pay_q.memread;
    assign bus.MemWrite_o  = pay_q.memwrite;
    assign bus.Branch_o    = pay_q.branch;
    assign bus.Jump_o      = pay_q.jump;
    assign bus.Illegal_o   = pay_q.illegal;
    assign bus.BrCond_o    = pay_q.brcond;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vector table, handshake corner
// sequences, and randomized traffic against a queue-based reference decoder.
module tb_alu_issue_stage;
    typedef struct packed {
        logic [4:0]  ctrl;
        logic [31:0] srca;
        logic [31:0] srcb;
        logic [31:0] st;
        logic [31:0] tgt;
        logic [4:0]  rd;
        logic        rw, mr, mw, br, jp, il;
        logic [2:0]  cond;
    } ent_t;

    typedef struct {
        logic [31:0] ins, pc, a, b;
        ent_t        exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    ent_t q[$];

    alu_issue_if bus();
    alu_issue_stage dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic ent_t mk(input logic [4:0] c, input logic [31:0] sa, sb, st, tg,
                                input logic [4:0] rd, input logic rw, mr, mw, br, jp, il,
                                input logic [2:0] cond);
        ent_t e;
        e = '{c, sa, sb, st, tg, rd, rw, mr, mw, br, jp, il, cond};
        return e;
    endfunction

    function automatic ent_t dut_ent();
        return mk(bus.ALUCtrl_o, bus.SrcA_o, bus.SrcB_o, bus.StoreData_o, bus.JmpTgt_o,
                  bus.Rd_o, bus.RegWrite_o, bus.MemRead_o, bus.MemWrite_o, bus.Branch_o,
                  bus.Jump_o, bus.Illegal_o, bus.BrCond_o);
    endfunction

    // Reference decoder built from the ISA field definitions using arithmetic shifts.
    function automatic ent_t ref_decode(input logic [31:0] ins, pc, a, b);
        ent_t        e;
        int          f3, f7, op, code;
        int          op_tbl[8];
        int          imm_tbl[8];
        logic signed [31:0] si;
        logic [31:0] immi, imms, immb, immu, immj, hi;
        bit          legal;
        op_tbl  = '{0, 2, 4, 5, 6, 7, 11, 12};
        imm_tbl = '{0, 3, 4, 5, 6, 9, 11, 12};
        e = '0;
        f3 = int'(ins[14:12]);
        f7 = int'(ins[31:25]);
        op = int'(ins[6:0]);
        si = ins;
        immi = 32'(si >>> 20);
        hi   = 32'(si >>> 25);
        imms = (hi << 5) | 32'(ins[11:7]);
        hi   = 32'(si >>> 31);
        immb = (hi << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
        immj = (hi << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
        immu = ins & 32'hFFFF_F000;
        legal = 1'b1;
        e.rd = ins[11:7];
        if (op == 'h33) begin
            e.srca = a; e.srcb = b; e.rw = 1'b1;
            if (f7 == 0) code = op_tbl[f3];
            else if (f7 == 'h20 && f3 == 0) code = 1;
            else if (f7 == 'h20 && f3 == 5) code = 8;
            else begin legal = 1'b0; code = 0; end
            e.ctrl = 5'(code);
        end else if (op == 'h13) begin
            e.srca = a; e.rw = 1'b1;
            code = imm_tbl[f3];
            if (f3 == 1 || f3 == 5) begin
                e.srcb = 32'(ins[24:20]);
                if (f3 == 5 && f7 == 'h20) code = 10;
                else if (f7 != 0) legal = 1'b0;
            end else e.srcb = immi;
            e.ctrl = 5'(code);
        end else if (op == 'h03) begin
            e.srca = a; e.srcb = immi; e.mr = 1'b1; e.rw = 1'b1;
        end else if (op == 'h23) begin
            e.srca = a; e.srcb = imms; e.mw = 1'b1; e.st = b;
        end else if (op == 'h63) begin
            e.ctrl = 5'd1; e.srca = a; e.srcb = b; e.br = 1'b1; e.cond = 3'(f3);
            e.tgt = pc + immb;
            if (f3 == 2 || f3 == 3) legal = 1'b0;
        end else if (op == 'h37) begin
            e.srcb = immu; e.rw = 1'b1;
        end else if (op == 'h17) begin
            e.srca = pc; e.srcb = immu; e.rw = 1'b1;
        end else if (op == 'h6F || op == 'h67) begin
            e.srca = pc; e.srcb = 32'd4; e.jp = 1'b1; e.rw = 1'b1;
            if (op == 'h6F) e.tgt = pc + immj;
            else begin
                e.tgt = (a + immi) & 32'hFFFF_FFFE;
                if (f3 != 0) legal = 1'b0;
            end
        end else legal = 1'b0;
        if (!legal) begin
            e = '0; e.il = 1'b1; e.rd = ins[11:7];
        end
        if (e.rd == 5'd0) e.rw = 1'b0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic chk_ent(input string name, input ent_t exp);
        ent_t act;
        act = dut_ent();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, pc, a, b, input logic fl, rdy);
        bus.in_valid_i  = v;
        bus.Instr_i     = ins;
        bus.PC_i        = pc;
        bus.RD1_i       = a;
        bus.RD2_i       = b;
        bus.flush_i     = fl;
        bus.out_ready_i = rdy;
    endtask

    vec_t        vecs[15];
    logic [6:0]  opc_tbl[10];
    ent_t        ent_a, ent_b;

    initial begin
        checks = 0;
        failures = 0;
        vecs[0]  = '{32'h402081B3, 32'h0, 32'd10, 32'd3,
                     mk(5'd1, 32'd10, 32'd3, 32'd0, 32'd0, 5'd3, 1, 0, 0, 0, 0, 0, 3'd0)};
        vecs[1]  = '{32'h40435293, 32'h0, 32'h8000_0000, 32'd0,
                     mk(5'd10, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 5'd5, 1, 0, 0, 0, 0, 0, 3'd0)};
        vecs[2]  = '{32'h0020C463, 32'h100, 32'd5, 32'd7,
                     mk(5'd1, 32'd5, 32'd7, 32'd0, 32'h108, 5'd8, 0, 0, 0, 1, 0, 0, 3'd4)};
        vecs[3]  = '{32'hFFFF_FFFF, 32'h44, 32'd1, 32'd2,
                     mk(5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd31, 0, 0, 0, 0, 0, 1, 3'd0)};
        vecs[4]  = '{32'h123450B7, 32'h8, 32'd9, 32'd9,
                     mk(5'd0, 32'd0, 32'h1234_5000, 32'd0, 32'd0, 5'd1, 1, 0, 0, 0, 0, 0, 3'd0)};
        vecs[5]  = '{32'h010000EF, 32'h200, 32'd0, 32'd0,
                     mk(5'd0, 32'h200, 32'd4, 32'd0, 32'h210, 5'd1, 1, 0, 0, 0, 1, 0, 3'd0)};
        vecs[6]  = '{32'h00008067, 32'h40, 32'h1235, 32'd0,
                     mk(5'd0, 32'h40, 32'd4, 32'd0, 32'h1234, 5'd0, 0, 0, 0, 0, 1, 0, 3'd0)};
        vecs[7]  = '{32'hFE20AE23, 32'h0, 32'h1000, 32'hDEAD_BEEF,
                     mk(5'd0, 32'h1000, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 32'd0, 5'd28, 0, 0, 1, 0, 0, 0, 3'd0)};
        vecs[8]  = '{32'h00812383, 32'h0, 32'h100, 32'd77,
                     mk(5'd0, 32'h100, 32'd8, 32'd0, 32'd0, 5'd7, 1, 1, 0, 0, 0, 0, 3'd0)};
        vecs[9]  = '{32'h022081B3, 32'h0, 32'd4, 32'd5,
                     mk(5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd3, 0, 0, 0, 0, 0, 1, 3'd0)};
        vecs[10] = '{32'h40109093, 32'h0, 32'd4, 32'd5,
                     mk(5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd1, 0, 0, 0, 0, 0, 1, 3'd0)};
        vecs[11] = '{32'h0020A463, 32'h100, 32'd4, 32'd5,
                     mk(5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd8, 0, 0, 0, 0, 0, 1, 3'd0)};
        vecs[12] = '{32'h00001217, 32'h1000, 32'd0, 32'd0,
                     mk(5'd0, 32'h1000, 32'h1000, 32'd0, 32'd0, 5'd4, 1, 0, 0, 0, 0, 0, 3'd0)};
        vecs[13] = '{32'hFFF00013, 32'h0, 32'd0, 32'd0,
                     mk(5'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0, 0, 0, 3'd0)};
        vecs[14] = '{32'h02007063, 32'hFFFF_FFF0, 32'd0, 32'd0,
                     mk(5'd1, 32'd0, 32'd0, 32'd0, 32'h10, 5'd0, 0, 0, 0, 1, 0, 0, 3'd7)};
        opc_tbl = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h00};

        // Reset state
        rst_n = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        #12;
        chk("rst_valid", 32'(bus.out_valid_o), 32'd0);
        chk_ent("rst_payload", '0);
        #10 rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
        tick();

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, vecs[i].ins, vecs[i].pc, vecs[i].a, vecs[i].b, 1'b0, 1'b1);
            tick();
            drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
            chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid_o), 32'd1);
            chk_ent($sformatf("vec%0d_entry", i), vecs[i].exp);
            tick();
            chk($sformatf("vec%0d_retire", i), 32'(bus.out_valid_o), 32'd0);
        end

        // Back-pressure: A held for 3 cycles, B waits and enters when out_ready rises
        ent_a = vecs[0].exp;
        ent_b = vecs[1].exp;
        drive(1'b1, vecs[0].ins, vecs[0].pc, vecs[0].a, vecs[0].b, 1'b0, 1'b0);
        tick();
        drive(1'b1, vecs[1].ins, vecs[1].pc, vecs[1].a, vecs[1].b, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp_hold_valid%0d", c), 32'(bus.out_valid_o), 32'd1);
            chk($sformatf("bp_in_ready%0d", c), 32'(bus.in_ready_o), 32'd0);
            chk_ent($sformatf("bp_hold_entry%0d", c), ent_a);
            tick();
        end
        bus.out_ready_i = 1'b1;
        #1;
        chk("bp_ready_rise", 32'(bus.in_ready_o), 32'd1);
        chk_ent("bp_a_at_retire", ent_a);
        tick();
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("bp_b_valid", 32'(bus.out_valid_o), 32'd1);
        chk_ent("bp_b_entry", ent_b);
        tick();
        chk_ent("bp_b_still", ent_b);
        bus.out_ready_i = 1'b1;
        tick();
        chk("bp_drained", 32'(bus.out_valid_o), 32'd0);

        // Illegal entry held, then flushed together with a same-cycle offer
        drive(1'b1, 32'hFFFF_FFFF, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        chk_ent("illegal_held", vecs[3].exp);
        drive(1'b1, vecs[0].ins, vecs[0].pc, vecs[0].a, vecs[0].b, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("flush_valid", 32'(bus.out_valid_o), 32'd0);
        chk_ent("flush_zero", '0);

        // Asynchronous reset between clock edges
        drive(1'b1, vecs[2].ins, vecs[2].pc, vecs[2].a, vecs[2].b, 1'b0, 1'b0);
        tick();
        chk("arst_loaded", 32'(bus.out_valid_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid_o), 32'd0);
        chk_ent("arst_zero", '0);
        rst_n = 1'b1;
        #1;
        chk("arst_in_ready", 32'(bus.in_ready_o), 32'd1);
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        tick();

        // Randomized traffic against the queue model
        q.delete();
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ins;
            logic        v, rdy, fl, exp_rdy;
            int          k;
            ins = $urandom;
            k = $urandom_range(0, 9);
            ins[6:0] = opc_tbl[k];
            k = $urandom_range(0, 3);
            if (k == 0) ins[31:25] = 7'h00;
            else if (k == 1) ins[31:25] = 7'h20;
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 15) == 0);
            drive(v, ins, $urandom, $urandom, $urandom, fl, rdy);
            #1;
            exp_rdy = (q.size() == 0) || rdy;
            chk("rnd_in_ready", 32'(bus.in_ready_o), 32'(exp_rdy));
            chk("rnd_valid", 32'(bus.out_valid_o), 32'(q.size() != 0));
            if (q.size() != 0) chk_ent("rnd_entry", q[0]);
            if (fl) q.delete();
            else begin
                if (q.size() != 0 && rdy) void'(q.pop_front());
                if (v && exp_rdy) q.push_back(ref_decode(ins, bus.PC_i, bus.RD1_i, bus.RD2_i));
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
